btb_update_queue: RTL and testbench

// - Buffers branch-resolution updates coming from execute/commit and drains them into the BTB line array.
// - Splits each update PC into a line index and a tag.
// - Drives a one-hot per-line write enable plus shared valid/is_jump/tag/target buses into the branch target lines.
// - Decouples bursty resolution traffic from the BTB's single write slot; writes are held off while lookup owns the array.

---
 rtl/btb_update_queue.sv | 132 +++++++++++++
 tb/tb_btb_update_queue.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/btb_update_queue.sv
// Branch-resolution update FIFO that drains one entry per cycle into the BTB line array.
// Optional feature: define BTB_UPD_MERGE_EN to fold a repeat update to the newest queued entry in place.
module btb_update_queue #(
    parameter int ADDR_WIDTH  = 32,
    parameter int INDEX_WIDTH = 6,
    parameter int TAG_WIDTH   = ADDR_WIDTH - INDEX_WIDTH - 2,
    parameter int DEPTH       = 4,
    localparam int LINES      = 1 << INDEX_WIDTH,
    localparam int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  upd_valid,
    output logic                  upd_ready,
    input  logic [ADDR_WIDTH-1:0] upd_pc,
    input  logic [ADDR_WIDTH-1:0] upd_target,
    input  logic                  upd_is_jump,
    input  logic                  upd_invalidate,
    input  logic                  stall,
    input  logic                  flush,
    output logic [LINES-1:0]      line_write_en,
    output logic                  line_valid,
    output logic                  line_is_jump,
    output logic [TAG_WIDTH-1:0]  line_pc,
    output logic [ADDR_WIDTH-1:0] line_target,
    output logic [CNT_W-1:0]      count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [TAG_WIDTH-1:0]   tag_mem [DEPTH];
    logic [INDEX_WIDTH-1:0] idx_mem [DEPTH];
    logic [ADDR_WIDTH-1:0]  tgt_mem [DEPTH];
    logic                   jmp_mem [DEPTH];
    logic                   inv_mem [DEPTH];

    logic [PTR_W-1:0] head_reg, tail_reg, wr_ptr;
    logic [CNT_W-1:0] count_reg;

    logic [TAG_WIDTH-1:0]   upd_tag;
    logic [INDEX_WIDTH-1:0] upd_idx;
    logic [INDEX_WIDTH-1:0] head_idx;
    logic full, empty, pop, push, alloc, merge_hit;
    logic unused_pc_bits;

    logic [LINES-1:0]      line_write_en_reg;
    logic                  line_valid_reg;
    logic                  line_is_jump_reg;
    logic [TAG_WIDTH-1:0]  line_pc_reg;
    logic [ADDR_WIDTH-1:0] line_target_reg;

    assign upd_tag        = upd_pc[ADDR_WIDTH-1:INDEX_WIDTH+2];
    assign upd_idx        = upd_pc[INDEX_WIDTH+1:2];
    assign unused_pc_bits = ^upd_pc[1:0];
    assign head_idx       = idx_mem[head_reg];

    assign full  = (count_reg == CNT_W'(DEPTH));
    assign empty = (count_reg == '0);
    assign pop   = ~rst & ~flush & ~stall & ~empty;

`ifdef BTB_UPD_MERGE_EN
    logic [PTR_W-1:0] tail_last;
    assign tail_last = tail_reg - PTR_W'(1);
    // The newest entry may only be rewritten if it is not leaving the queue this very edge.
    assign merge_hit = ~empty
                     & (tag_mem[tail_last] == upd_tag)
                     & (idx_mem[tail_last] == upd_idx)
                     & ~(pop & (count_reg == CNT_W'(1)));
    assign wr_ptr    = merge_hit ? tail_last : tail_reg;
`else
    assign merge_hit = 1'b0;
    assign wr_ptr    = tail_reg;
`endif

    assign upd_ready = ~rst & ~flush & (~full | merge_hit);
    assign push      = upd_valid & upd_ready;
    assign alloc     = push & ~merge_hit;

    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr] <= upd_tag;
            idx_mem[wr_ptr] <= upd_idx;
            tgt_mem[wr_ptr] <= upd_target;
            jmp_mem[wr_ptr] <= upd_is_jump;
            inv_mem[wr_ptr] <= upd_invalidate;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (pop)
                head_reg <= head_reg + PTR_W'(1);
            if (alloc)
                tail_reg <= tail_reg + PTR_W'(1);
            count_reg <= count_reg + CNT_W'(alloc) - CNT_W'(pop);
        end
    end

    // Data buses only move on a pop so the line array sees stable fields between writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            line_valid_reg   <= 1'b0;
            line_is_jump_reg <= 1'b0;
            line_pc_reg      <= '0;
            line_target_reg  <= '0;
        end else if (pop) begin
            line_valid_reg   <= ~inv_mem[head_reg];
            line_is_jump_reg <= jmp_mem[head_reg];
            line_pc_reg      <= tag_mem[head_reg];
            line_target_reg  <= tgt_mem[head_reg];
        end
    end

    for (genvar gi = 0; gi < LINES; gi++) begin : g_strobe
        always_ff @(posedge clk) begin
            if (rst)
                line_write_en_reg[gi] <= 1'b0;
            else
                line_write_en_reg[gi] <= pop & (head_idx == INDEX_WIDTH'(gi));
        end
    end

    assign line_write_en = line_write_en_reg;
    assign line_valid    = line_valid_reg;
    assign line_is_jump  = line_is_jump_reg;
    assign line_pc       = line_pc_reg;
    assign line_target   = line_target_reg;
    assign count         = count_reg;
endmodule

// File: tb/tb_btb_update_queue.sv
// Randomized scoreboard bench for btb_update_queue against a queue-based reference model.
// Honours BTB_UPD_MERGE_EN in the model the same way the design does.
module tb_btb_update_queue;
    localparam int AW = 32, IW = 6, TW = 24, DEPTH = 4, LINES = 64;

    logic clk = 1'b0;
    logic rst, upd_valid, upd_is_jump, upd_invalidate, stall, flush;
    logic [AW-1:0] upd_pc, upd_target;
    logic upd_ready, line_valid, line_is_jump;
    logic [LINES-1:0] line_write_en;
    logic [TW-1:0] line_pc;
    logic [AW-1:0] line_target;
    logic [2:0] count;

    btb_update_queue dut (
        .clk(clk), .rst(rst), .upd_valid(upd_valid), .upd_ready(upd_ready),
        .upd_pc(upd_pc), .upd_target(upd_target), .upd_is_jump(upd_is_jump),
        .upd_invalidate(upd_invalidate), .stall(stall), .flush(flush),
        .line_write_en(line_write_en), .line_valid(line_valid), .line_is_jump(line_is_jump),
        .line_pc(line_pc), .line_target(line_target), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [TW-1:0] tag;
        logic [IW-1:0] idx;
        logic [AW-1:0] tgt;
        logic          jmp;
        logic          inv;
    } upd_t;

    upd_t model_q[$];
    upd_t exp_q[$];
    logic [57:0] last_bus;
    bit armed = 0;
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic upd_t mk(input logic [AW-1:0] pc, input logic [AW-1:0] tgt,
                                input logic j, input logic i);
        upd_t u;
        u.tag = pc[AW-1:IW+2];
        u.idx = pc[IW+1:2];
        u.tgt = tgt;
        u.jmp = j;
        u.inv = i;
        return u;
    endfunction

    function automatic bit model_pop();
        return !rst && !flush && !stall && model_q.size() != 0;
    endfunction

    function automatic bit model_merge();
`ifdef BTB_UPD_MERGE_EN
        upd_t u;
        u = mk(upd_pc, upd_target, upd_is_jump, upd_invalidate);
        if (model_q.size() == 0) return 0;
        if (model_q[$].tag != u.tag || model_q[$].idx != u.idx) return 0;
        if (model_pop() && model_q.size() == 1) return 0;
        return 1;
`else
        return 0;
`endif
    endfunction

    function automatic bit model_ready();
        return !rst && !flush && (model_q.size() < DEPTH || model_merge());
    endfunction

    // Reference model: advances on each edge from the inputs that were stable before it.
    always @(posedge clk) begin : model_b
        bit do_pop, do_merge, do_push;
        upd_t u, e;
        if (rst) begin
            model_q.delete();
            exp_q.delete();
            last_bus = '0;
            armed = 1;
        end else if (flush) begin
            model_q.delete();
        end else begin
            do_pop   = model_pop();
            do_merge = model_merge();
            do_push  = upd_valid && model_ready();
            u = mk(upd_pc, upd_target, upd_is_jump, upd_invalidate);
            if (do_pop) begin
                e = model_q.pop_front();
                exp_q.push_back(e);
                last_bus = {~e.inv, e.jmp, e.tag, e.tgt};
            end
            if (do_push) begin
                if (do_merge) model_q[model_q.size()-1] = u;
                else model_q.push_back(u);
            end
        end
    end

    // Monitor: compares DUT outputs mid-cycle against the scoreboard.
    always @(negedge clk) begin : mon_b
        upd_t e;
        if (armed) begin
            check("count", 64'(count), 64'(model_q.size()));
            check("ready", 64'(upd_ready), 64'(model_ready()));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("strobe", 64'(line_write_en), 64'(1) << e.idx);
            end else begin
                check("strobe_idle", 64'(line_write_en), 64'd0);
            end
            check("line_bus", 64'({line_valid, line_is_jump, line_pc, line_target}), 64'(last_bus));
        end
    end

    task automatic step(input bit v, input logic [AW-1:0] pc, input logic [AW-1:0] tgt,
                        input bit j, input bit i, input bit s, input bit f, input bit r);
        upd_valid = v; upd_pc = pc; upd_target = tgt; upd_is_jump = j;
        upd_invalidate = i; stall = s; flush = f; rst = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        check("reset_count", 64'(count), 64'd0);
        check("reset_ready", 64'(upd_ready), 64'd0);

        // Single update, two-edge latency to the strobe
        step(1, 32'h0000_1008, 32'h0000_2000, 1, 0, 0, 0, 0);
        idle(1);
        check("t1_strobe", 64'(line_write_en), 64'h4);
        check("t1_pc", 64'(line_pc), 64'h10);
        check("t1_target", 64'(line_target), 64'h2000);
        check("t1_valid", 64'(line_valid), 64'd1);
        check("t1_count", 64'(count), 64'd0);
        idle(2);

        // Fill under stall, refuse a fifth, then drain in order
        for (int k = 0; k < 4; k++)
            step(1, 32'h0000_2000 + 32'(k * 4), 32'hA000 + 32'(k), k[0], 0, 1, 0, 0);
        check("full_count", 64'(count), 64'd4);
        upd_valid = 1; upd_pc = 32'h0000_2040; stall = 1;
        #1;
        check("full_ready", 64'(upd_ready), 64'd0);
        step(1, 32'h0000_2040, 32'hBEEF, 0, 0, 1, 0, 0);
        idle(6);

        // Flush with an offered update
        for (int k = 0; k < 3; k++)
            step(1, 32'h0000_3000 + 32'(k * 4), 32'hC000 + 32'(k), 0, 0, 1, 0, 0);
        step(1, 32'h0000_30F0, 32'hDEAD, 1, 0, 0, 1, 0);
        check("flush_count", 64'(count), 64'd0);
        check("flush_strobe", 64'(line_write_en), 64'd0);
        idle(3);

        // Invalidate
        step(1, 32'h0000_0040, 32'h1234, 0, 1, 0, 0, 0);
        idle(1);
        check("inv_strobe", 64'(line_write_en), 64'(1) << 16);
        check("inv_valid", 64'(line_valid), 64'd0);
        idle(2);

        // Reset mid-drain
        step(1, 32'h0000_4000, 32'h1111, 1, 0, 1, 0, 0);
        step(1, 32'h0000_4004, 32'h2222, 1, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        check("rst_strobe", 64'(line_write_en), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_bus", 64'({line_valid, line_is_jump, line_pc, line_target}), 64'd0);
        idle(2);

        // Same-line updates back to back
        step(1, 32'h0000_0100, 32'h0000_AAAA, 0, 0, 1, 0, 0);
        step(1, 32'h0000_0100, 32'h0000_BBBB, 1, 0, 1, 0, 0);
`ifdef BTB_UPD_MERGE_EN
        check("merge_count", 64'(count), 64'd1);
`else
        check("merge_count", 64'(count), 64'd2);
`endif
        idle(4);

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            logic [AW-1:0] pc;
            pc = (32'($urandom_range(0, 1)) << 12) | (32'($urandom_range(0, 3)) << 2);
            step($urandom_range(0, 9) < 7, pc, $urandom, 1'($urandom), 1'($urandom_range(0, 7) == 0),
                 $urandom_range(0, 9) < 3, $urandom_range(0, 29) == 0, $urandom_range(0, 99) == 0);
        end
        idle(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
